// File: rtl/serial_frame_fifo_pkg.sv
// Shared constants, frame type and sizing helper for the serial frame FIFO.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package i2s_quest_pkg;

    localparam int DEF_WIDTH      = 16;
    localparam int DEF_CHANNELS   = 2;
    localparam int DEF_DEPTH      = 64;
    localparam int DEF_LOW_WATER  = 16;
    localparam int DEF_HIGH_WATER = 48;

    // One frame at the default geometry; channel 0 occupies the LSBs.
    typedef logic [DEF_CHANNELS*DEF_WIDTH-1:0] frame_t;

    // A level counter must represent 0..depth inclusive.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/serial_frame_fifo_if.sv
// Frame delivery bus between the FIFO and the I2S transmitter.
// Latency: n/a (signal bundle only).
// Backpressure: none; the consumer pulls one frame per ready pulse.
//   ready      consumer -> FIFO  one-cycle request for the next frame
//   data       FIFO -> consumer  current frame, channel 0 in the LSBs
//   data_valid FIFO -> consumer  one-cycle pulse when data was refreshed
interface serial_frame_fifo_if #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 2
);
    logic                      ready;
    logic [CHANNELS*WIDTH-1:0] data;
    logic                      data_valid;

    modport master (input ready, output data, output data_valid);
    modport slave  (output ready, input data, input data_valid);
endinterface

// File: rtl/serial_frame_fifo_serial_deser.sv
// Oversampling deserialiser: syncs the Pi's bit clock/data, assembles LSB-first frames.
// Latency: 3 clk from the last bit's rpi_clk rise to frame_vld_o (2 sync + edge).
// Backpressure: none; frame_vld_o is a one-cycle strobe the parent must take or drop.
//   clk, rst        system clock, synchronous active-high reset
//   rpi_clk_i       async bit clock (high/low phases >= 3 clk)
//   serial_i        async serial data, sampled on rpi_clk rising edges
//   rpi_sync_i      async realign; high discards the partial word and frame
//   frame_o         assembled frame, channel 0 in the LSBs
//   frame_vld_o     one-cycle strobe when frame_o holds a complete frame
module serial_deser #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rpi_clk_i,
    input  logic                      serial_i,
    input  logic                      rpi_sync_i,
    output logic [CHANNELS*WIDTH-1:0] frame_o,
    output logic                      frame_vld_o
);

    localparam int BW = (WIDTH > 1)    ? $clog2(WIDTH)    : 1;
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [1:0]                clk_sync_q;
    logic [1:0]                dat_sync_q;
    logic [1:0]                rsy_sync_q;
    // Fills with ones as real samples reach the end of the synchronisers, so
    // the reset-forced zeros are never taken as a genuine low phase.
    logic [1:0]                fill_q;
    logic                      armed_q;
    logic                      prev_q;
    logic [BW-1:0]             bitcnt_q;
    logic [CW-1:0]             chan_q;
    logic [WIDTH-1:0]          word_q;
    logic [CHANNELS*WIDTH-1:0] frame_q;
    logic                      frame_vld_q;

    logic s_clk;
    logic s_dat;
    logic s_sync;
    logic rise;

    assign s_clk  = clk_sync_q[1];
    assign s_dat  = dat_sync_q[1];
    assign s_sync = rsy_sync_q[1];
    assign rise   = armed_q & s_clk & ~prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q <= '0;
            dat_sync_q <= '0;
            rsy_sync_q <= '0;
            fill_q     <= '0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], rpi_clk_i};
            dat_sync_q <= {dat_sync_q[0], serial_i};
            rsy_sync_q <= {rsy_sync_q[0], rpi_sync_i};
            fill_q     <= {fill_q[0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            armed_q     <= 1'b0;
            prev_q      <= 1'b0;
            bitcnt_q    <= '0;
            chan_q      <= '0;
            word_q      <= '0;
            frame_q     <= '0;
            frame_vld_q <= 1'b0;
        end else begin
            prev_q      <= s_clk;
            frame_vld_q <= 1'b0;
            if (fill_q[1] && !s_clk) begin
                armed_q <= 1'b1;
            end
            // Realign takes priority over a coincident bit edge.
            if (s_sync) begin
                bitcnt_q <= '0;
                chan_q   <= '0;
                word_q   <= '0;
            end else if (rise) begin
                if (bitcnt_q == BW'(WIDTH - 1)) begin
                    // The last bit goes straight into the slot, bypassing word_q.
                    frame_q[int'(chan_q)*WIDTH +: WIDTH] <= {s_dat, word_q[WIDTH-2:0]};
                    word_q   <= '0;
                    bitcnt_q <= '0;
                    if (chan_q == CW'(CHANNELS - 1)) begin
                        chan_q      <= '0;
                        frame_vld_q <= 1'b1;
                    end else begin
                        chan_q <= chan_q + 1'b1;
                    end
                end else begin
                    word_q[bitcnt_q] <= s_dat;
                    bitcnt_q         <= bitcnt_q + 1'b1;
                end
            end
        end
    end

    assign frame_o     = frame_q;
    assign frame_vld_o = frame_vld_q;

endmodule

// File: rtl/serial_frame_fifo.sv
// Serial-input frame FIFO: buffers frames from the Pi and hands one out per ready pulse.
// Latency: last bit's rpi_clk rise -> level increment 4 clk; ready -> data/data_valid 1 clk.
// Backpressure: rpi_interrupt throttles the Pi with LOW/HIGH hysteresis; full FIFO drops and flags overflow.
//   clk, rst                   system clock, synchronous active-high reset
//   rpi_clk, serial, rpi_sync  async inputs from the Pi
//   clear_flags                one-cycle pulse clearing overflow/underrun
//   bus (master)               ready in, data/data_valid out
//   rpi_interrupt              high asks the Pi for more frames
//   level                      frames currently stored, 0..DEPTH
//   overflow, underrun         sticky error flags
// Build option: define UNDERRUN_HOLD_EN to keep the previous frame on data when
// a ready arrives with the FIFO empty; otherwise data goes to zero.
module serial_frame_fifo
    import i2s_quest_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int CHANNELS   = DEF_CHANNELS,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int LOW_WATER  = DEF_LOW_WATER,
    parameter int HIGH_WATER = DEF_HIGH_WATER
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rpi_clk,
    input  logic                          serial,
    input  logic                          rpi_sync,
    input  logic                          clear_flags,
    serial_frame_fifo_if.master           bus,
    output logic                          rpi_interrupt,
    output logic [level_width(DEPTH)-1:0] level,
    output logic                          overflow,
    output logic                          underrun
);

    localparam int FW = CHANNELS * WIDTH;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_width(DEPTH);

    logic [FW-1:0] frame;
    logic          frame_vld;

    serial_deser #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS)
    ) u_deser (
        .clk         (clk),
        .rst         (rst),
        .rpi_clk_i   (rpi_clk),
        .serial_i    (serial),
        .rpi_sync_i  (rpi_sync),
        .frame_o     (frame),
        .frame_vld_o (frame_vld)
    );

    logic [FW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_d;
    logic [FW-1:0] data_q;
    logic          data_vld_q;
    logic          irq_q;
    logic          ovf_q;
    logic          und_q;

    logic do_rd;
    logic do_wr;
    logic ovf_set;
    logic und_set;

    // A full FIFO still accepts a frame when the same cycle frees a slot.
    assign do_rd   = bus.ready && (level_q != '0);
    assign do_wr   = frame_vld && ((level_q != LW'(DEPTH)) || do_rd);
    assign ovf_set = frame_vld && !do_wr;
    assign und_set = bus.ready && (level_q == '0);

    always_comb begin
        level_d = level_q;
        if (do_wr && !do_rd) begin
            level_d = level_q + 1'b1;
        end else if (!do_wr && do_rd) begin
            level_d = level_q - 1'b1;
        end
    end

    // Storage is not reset; an empty level makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= frame;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            data_q     <= '0;
            data_vld_q <= 1'b0;
            irq_q      <= 1'b1;
            ovf_q      <= 1'b0;
            und_q      <= 1'b0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_rd) begin
                data_q   <= mem_q[rd_ptr_q];
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end else if (und_set) begin
`ifdef UNDERRUN_HOLD_EN
                data_q <= data_q;
`else
                data_q <= '0;
`endif
            end
            data_vld_q <= do_rd;
            level_q    <= level_d;
            // Hysteresis acts on the post-update level; between the marks it holds.
            if (level_d <= LW'(LOW_WATER)) begin
                irq_q <= 1'b1;
            end else if (level_d >= LW'(HIGH_WATER)) begin
                irq_q <= 1'b0;
            end
            // A set event in the same cycle beats clear_flags.
            ovf_q <= ovf_set | (ovf_q & ~clear_flags);
            und_q <= und_set | (und_q & ~clear_flags);
        end
    end

    assign bus.data       = data_q;
    assign bus.data_valid = data_vld_q;
    assign rpi_interrupt  = irq_q;
    assign level          = level_q;
    assign overflow       = ovf_q;
    assign underrun       = und_q;

endmodule

// File: tb/tb_serial_frame_fifo.sv
// Bench for serial_frame_fifo: queue-based reference model checked every cycle, plus literal checks.
// Latency: model applies a frame 4 clk after its last rpi_clk rise, a read on the edge after ready.
// Backpressure: bench pulls frames with ready pulses; random phase mixes reads and clears.
module tb_serial_frame_fifo;
    import i2s_quest_pkg::*;

    localparam int W  = 16;
    localparam int C  = 2;
    localparam int D  = 64;
    localparam int LO = 16;
    localparam int HI = 48;
    localparam int LW = level_width(D);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rpi_clk = 1'b0;
    logic          serial = 1'b0;
    logic          rpi_sync = 1'b0;
    logic          clear_flags = 1'b0;
    logic          rpi_interrupt;
    logic          overflow;
    logic          underrun;
    logic [LW-1:0] level;

    serial_frame_fifo_if #(.WIDTH(W), .CHANNELS(C)) bus ();

    serial_frame_fifo #(
        .WIDTH(W), .CHANNELS(C), .DEPTH(D), .LOW_WATER(LO), .HIGH_WATER(HI)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rpi_clk       (rpi_clk),
        .serial        (serial),
        .rpi_sync      (rpi_sync),
        .clear_flags   (clear_flags),
        .bus           (bus),
        .rpi_interrupt (rpi_interrupt),
        .level         (level),
        .overflow      (overflow),
        .underrun      (underrun)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model state.
    frame_t mq[$];
    int     pend_due[$];
    frame_t pend_frm[$];
    frame_t m_data = '0;
    bit     m_dv   = 1'b0;
    bit     m_int  = 1'b1;
    bit     m_ovf  = 1'b0;
    bit     m_und  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: one step per rising clock edge.
    initial begin
        bit     rd, wr, s_ovf, s_und;
        frame_t wf;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                mq.delete(); pend_due.delete(); pend_frm.delete();
                m_data = '0; m_dv = 0; m_int = 1; m_ovf = 0; m_und = 0;
            end else begin
                rd = bus.ready; wr = 0; s_ovf = 0; s_und = 0; wf = '0;
                if (pend_due.size() > 0 && pend_due[0] == cyc) begin
                    wr = 1;
                    wf = pend_frm.pop_front();
                    void'(pend_due.pop_front());
                end
                m_dv = 0;
                if (rd) begin
                    if (mq.size() > 0) begin
                        m_data = mq.pop_front();
                        m_dv   = 1;
                    end else begin
                        s_und = 1;
`ifndef UNDERRUN_HOLD_EN
                        m_data = '0;
`endif
                    end
                end
                if (wr) begin
                    if (mq.size() < D) mq.push_back(wf);
                    else s_ovf = 1;
                end
                if (mq.size() <= LO) m_int = 1;
                else if (mq.size() >= HI) m_int = 0;
                m_ovf = s_ovf | (m_ovf & ~clear_flags);
                m_und = s_und | (m_und & ~clear_flags);
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                check("m_level", level, mq.size());
                check("m_data", bus.data, m_data);
                check("m_dv", bus.data_valid, m_dv);
                check("m_int", rpi_interrupt, m_int);
                check("m_ovf", overflow, m_ovf);
                check("m_und", underrun, m_und);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One bit: low phase with data set up, then a rising edge held 4 clk.
    task automatic send_bit(input bit b, input bit last, input bit rd_align, input frame_t f);
        rpi_clk = 1'b0;
        serial  = b;
        tick(4);
        rpi_clk = 1'b1;
        if (last) begin
            pend_due.push_back(cyc + 4);
            pend_frm.push_back(f);
        end
        tick(3);
        if (last && rd_align) bus.ready = 1'b1;
        tick(1);
        if (last && rd_align) bus.ready = 1'b0;
    endtask

    task automatic send_frame(input frame_t f, input bit rd_align);
        for (int i = 0; i < C*W; i++) send_bit(f[i], i == C*W-1, rd_align, f);
    endtask

    task automatic rd_pulse();
        bus.ready = 1'b1;
        tick(1);
        bus.ready = 1'b0;
    endtask

    task automatic clr_pulse();
        clear_flags = 1'b1;
        tick(1);
        clear_flags = 1'b0;
    endtask

    function automatic frame_t fill_frame(input int k);
        return {16'(k) ^ 16'h5A00, 16'(k)};
    endfunction

    initial begin
        bus.ready = 1'b0;
        tick(4);
        rst = 1'b0;
        tick(3);

        check("rst_level", level, 0);
        check("rst_data", bus.data, 0);
        check("rst_dv", bus.data_valid, 0);
        check("rst_int", rpi_interrupt, 1);
        check("rst_ovf", overflow, 0);
        check("rst_und", underrun, 0);

        // Read with nothing stored.
        rd_pulse();
        check("und_flag", underrun, 1);
        check("und_data", bus.data, 0);
        check("und_dv", bus.data_valid, 0);
        clr_pulse();
        check("und_clear", underrun, 0);

        // Basic frame through.
        send_frame(32'hBEEF1234, 1'b0);
        check("f1_level", level, 1);
        rd_pulse();
        check("f1_data", bus.data, 32'hBEEF1234);
        check("f1_dv", bus.data_valid, 1);
        check("f1_level0", level, 0);
        tick(1);
        check("f1_dv_end", bus.data_valid, 0);

        // Realign after a partial word.
        for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b0, 1'b0, '0);
        rpi_clk  = 1'b0;
        rpi_sync = 1'b1;
        tick(3);
        rpi_sync = 1'b0;
        tick(3);
        send_frame(32'h00020001, 1'b0);
        check("sync_level", level, 1);
        rd_pulse();
        check("sync_data", bus.data, 32'h00020001);
        rd_pulse();
        check("hold_und", underrun, 1);
`ifdef UNDERRUN_HOLD_EN
        check("hold_data", bus.data, 32'h00020001);
`else
        check("hold_data", bus.data, 0);
`endif
        clr_pulse();

        // Fill to DEPTH, then one more.
        for (int k = 1; k <= D; k++) begin
            send_frame(fill_frame(k), 1'b0);
            check("fill_level", level, k);
            check("fill_int", rpi_interrupt, (k < HI) ? 1 : 0);
        end
        send_frame(32'hDEAD0065, 1'b0);
        check("ovf_set", overflow, 1);
        check("ovf_level", level, D);
        clr_pulse();
        check("ovf_clear", overflow, 0);

        // Full FIFO, write and read on the same edge.
        send_frame(32'hCAFEF00D, 1'b1);
        check("same_ovf", overflow, 0);
        check("same_level", level, D);
        check("same_data", bus.data, fill_frame(1));
        check("same_dv", bus.data_valid, 1);

        // Drain 64 -> 16.
        for (int n = 1; n <= D - LO; n++) begin
            rd_pulse();
            check("drain_data", bus.data, fill_frame(n + 1));
            check("drain_int", rpi_interrupt, ((D - n) <= LO) ? 1 : 0);
        end

        // Refill 16 -> 47: interrupt holds high.
        for (int j = 1; j <= HI - 1 - LO; j++) begin
            send_frame(fill_frame(100 + j), 1'b0);
            check("refill_level", level, LO + j);
            check("refill_int", rpi_interrupt, 1);
        end

        // Drain everything; the same-edge frame is the 16th out here.
        for (int i = 1; i <= HI - 1; i++) begin
            rd_pulse();
            if (i <= 15)       check("final_data", bus.data, fill_frame(49 + i));
            else if (i == 16)  check("final_cafe", bus.data, 32'hCAFEF00D);
            else               check("final_data", bus.data, fill_frame(100 + i - 16));
        end
        check("final_level", level, 0);
        clr_pulse();

        // Random frames with random reads and flag clears.
        fork
            begin
                repeat (20) send_frame(frame_t'($urandom), 1'b0);
            end
            begin
                repeat (20 * C * W * 8 + 16) begin
                    bus.ready   = ($urandom_range(0, 99) == 0);
                    clear_flags = ($urandom_range(0, 299) == 0);
                    tick(1);
                end
                bus.ready   = 1'b0;
                clear_flags = 1'b0;
            end
        join
        tick(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_frame_fifo.md
Name: serial_frame_fifo

Overview:
Parametrised successor to the single-word Raspberry Pi serial input stage. Oversamples the Pi's bit clock and data in the system clock domain and deserialises LSB-first words. It groups CHANNELS words into one frame and buffers DEPTH frames in a FIFO. It presents one frame per `ready` request to the I2S transmitter and drives a hysteretic `rpi_interrupt` to throttle the Pi.

Parameters:
- WIDTH, 16, bits per sample word.
- CHANNELS, 2, words per frame (interleaved ch0 first).
- DEPTH, 64, FIFO depth in frames; power of 2, ≥4.
- LOW_WATER, 16, level at or below which more data is requested.
- HIGH_WATER, 48, level at or above which the request is dropped; LOW_WATER < HIGH_WATER ≤ DEPTH.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- rpi_clk  in  1  async bit clock from the Pi.
- serial  in  1  async serial data from the Pi.
- rpi_sync  in  1  async word/frame realign; high discards the partial frame.
- ready  in  1  one-cycle pulse (clk domain) requesting the next frame.
- clear_flags  in  1  one-cycle pulse clearing the sticky flags.
- data  out  CHANNELS*WIDTH  current output frame; ch0 in the LSBs.
- data_valid  out  1  one-cycle pulse when `data` is updated from the FIFO.
- rpi_interrupt  out  1  high = Pi must send more frames.
- level  out  $clog2(DEPTH)+1  frames currently stored.
- overflow  out  1  sticky; a frame was dropped because the FIFO was full.
- underrun  out  1  sticky; `ready` arrived while the FIFO was empty.

Behaviour:
- Reset values:
  - data=0, data_valid=0, level=0, overflow=0, underrun=0, rpi_interrupt=1.
  - Pointers, bit counter and channel index = 0; synchroniser flops = 0.
- Synchronisation and edge detection:
  - rpi_clk, serial and rpi_sync each pass a 2-flop synchroniser.
  - Edge detect: rising edge = synced rpi_clk is 1 and its previous value is 0.
  - The detector arms only after one low sample post-reset, so a high rpi_clk at reset release is not counted.
  - Requirement on the Pi: rpi_clk high and low phases each ≥3 clk periods.
- Deserialisation:
  - On each detected edge, synced serial is written to bit[bitcnt] of the current word, LSB first, and bitcnt increments.
  - At bitcnt=WIDTH-1 the word is stored into the frame assembler slot [chan], bitcnt wraps to 0 and chan increments.
  - When chan wraps from CHANNELS-1, the frame write strobe is issued the next clk cycle.
  - Synced rpi_sync=1 clears bitcnt and chan and discards partial data; rpi_sync wins over a simultaneous edge.
- FIFO write:
  - Accepted if level<DEPTH, or if level==DEPTH and a read occurs in the same cycle.
  - Otherwise the frame is dropped, overflow is set and pointers are unchanged.
- FIFO read on `ready`:
  - If level>0: data<=head frame on the next clk edge, data_valid=1 for that one cycle, read pointer advances.
  - If level==0: underrun is set, data<=0, data_valid stays 0.
- Simultaneous read and write: both performed; level unchanged.
- Level and flag behaviour:
  - Pointers wrap modulo DEPTH; `level` is exact, 0..DEPTH.
  - rpi_interrupt is set when the updated level ≤ LOW_WATER and cleared when the updated level ≥ HIGH_WATER; otherwise it holds.
  - clear_flags clears overflow and underrun; a same-cycle set event wins.
- Reset mid-stream: the partial frame and all stored frames are discarded; the Pi must realign via rpi_sync.
- Latency: last bit's rpi_clk edge → level increment = 4 clk cycles (2 sync + edge + write).

Optional Feature:
- UNDERRUN_HOLD_EN
  - Defined: on underrun, `data` holds the previous frame instead of going to 0.
  - Undefined: `data` is 0 on underrun.
- underrun flag behaviour is identical in both cases.

Decomposition:
- Package i2s_quest_pkg:
  - Default WIDTH/CHANNELS/DEPTH constants.
  - Frame typedef (CHANNELS×WIDTH packed).
  - Level width function.
- Sub-module serial_deser: synchronisers, edge detect, bit/channel counters, frame assembler, frame strobe.
- serial_frame_fifo: instantiates serial_deser; contains FIFO storage, pointers, level, watermark and flag logic.

Test Plan:
- Reset, then shift frame ch0=16'h1234, ch1=16'hBEEF, then `ready` → data=32'hBEEF1234, one data_valid pulse, level 1→0.
- Pulse `ready` after reset with nothing sent → underrun=1, data=0 (hold last frame with UNDERRUN_HOLD_EN), data_valid=0; clear_flags → underrun=0.
- Write 64 frames without reads → level=64, rpi_interrupt drops when level reaches 48; 65th frame → overflow=1, level stays 64, head frame unchanged.
- Assert rpi_sync after 7 bits, then send full frame 16'h0001/16'h0002 → only that frame stored; first read returns 32'h00020001.
- With level=64, last bit of a new frame lands in the same cycle as `ready` → no overflow, level stays 64, the new frame is read out 64th.
- Drain from 48 to 16 → rpi_interrupt rises exactly at the level=16 update and stays high while level refills up to 47.
